// File: rtl/ibex_rf_wport_arbiter.sv
// Single write port for the FPGA register file: arbitrates EX and LSU writeback onto one registered port.
// Define IBEX_RF_ZERO_INIT_EN to zero x1..xN after reset (LUT-RAM has no reset of its own).
module ibex_rf_wport_arbiter #(
    parameter bit RV32E     = 1'b0,
    parameter int DataWidth = 32,
    parameter int MaxWait   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_addr_i,
    input  logic [DataWidth-1:0] ex_data_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [4:0]           lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_data_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 init_done_o
);

    localparam int NumWords = RV32E ? 16 : 32;

    logic                 w_run;
    logic                 w_init_wr;
    logic [4:0]           w_init_addr;
    logic                 w_force_lsu;
    logic                 w_ex_gnt;
    logic                 w_lsu_gnt;
    logic                 w_hs;
    logic [4:0]           w_addr_raw;
    logic [4:0]           w_addr;
    logic [DataWidth-1:0] w_data;

    logic [3:0]           r_wait;
    logic                 r_we;
    logic [4:0]           r_waddr;
    logic [DataWidth-1:0] r_wdata;

`ifdef IBEX_RF_ZERO_INIT_EN
    typedef enum logic {S_INIT, S_RUN} state_e;

    localparam logic [4:0] LastAddr = 5'(NumWords - 1);

    state_e     r_state;
    state_e     w_state_next;
    logic [4:0] r_init_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_INIT;
            r_init_cnt <= 5'd1;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 5'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_init_wr    = 1'b0;
        if (r_state == S_INIT) begin
            w_init_wr = 1'b1;
            if (r_init_cnt == LastAddr) w_state_next = S_RUN;
        end
    end

    assign w_run       = (r_state == S_RUN);
    assign w_init_addr = r_init_cnt;
`else
    assign w_run       = 1'b1;
    assign w_init_wr   = 1'b0;
    assign w_init_addr = 5'd0;
`endif

    // MaxWait of 0 means EX always has priority; avoid an always-true compare.
    generate
        if (MaxWait == 0) begin : g_no_force
            assign w_force_lsu = 1'b0;
        end else begin : g_force
            assign w_force_lsu = (r_wait >= 4'(MaxWait));
        end
    endgenerate

    assign w_lsu_gnt  = w_run && lsu_valid_i && (w_force_lsu || !ex_valid_i);
    assign w_ex_gnt   = w_run && ex_valid_i && !w_lsu_gnt;
    assign w_hs       = w_ex_gnt || w_lsu_gnt;
    assign w_addr_raw = w_lsu_gnt ? lsu_addr_i : ex_addr_i;
    assign w_data     = w_lsu_gnt ? lsu_data_i : ex_data_i;
    assign w_addr     = RV32E ? {1'b0, w_addr_raw[3:0]} : w_addr_raw;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wait <= 4'd0;
        end else if (w_lsu_gnt) begin
            r_wait <= 4'd0;
        end else if (lsu_valid_i && r_wait != 4'd15) begin
            r_wait <= r_wait + 4'd1;
        end
    end

    // Address/data only move on a real write so the bypass view stays stable when idle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= '0;
        end else if (w_init_wr) begin
            r_we    <= 1'b1;
            r_waddr <= w_init_addr;
            r_wdata <= '0;
        end else if (w_hs) begin
            r_we    <= (w_addr != 5'd0);
            r_waddr <= w_addr;
            r_wdata <= w_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign ex_ready_o  = w_ex_gnt;
    assign lsu_ready_o = w_lsu_gnt;
    assign rf_we_o     = r_we;
    assign rf_waddr_o  = r_waddr;
    assign rf_wdata_o  = r_wdata;
    assign init_done_o = w_run;

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Directed bench for ibex_rf_wport_arbiter: a 32-register instance plus an RV32E instance on shared inputs.
module tb_ibex_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        ex_valid, lsu_valid;
    logic [4:0]  ex_addr, lsu_addr;
    logic [31:0] ex_data, lsu_data;

    logic        ex_ready, lsu_ready, we, done;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        e_ex_ready, e_lsu_ready, e_we, e_done;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    ibex_rf_wport_arbiter #(.RV32E(1'b0), .DataWidth(32), .MaxWait(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata), .init_done_o(done)
    );

    ibex_rf_wport_arbiter #(.RV32E(1'b1), .DataWidth(32), .MaxWait(4)) dut_e (
        .clk_i(clk), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid), .ex_ready_o(e_ex_ready), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(e_lsu_ready), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .rf_we_o(e_we), .rf_waddr_o(e_waddr), .rf_wdata_o(e_wdata), .init_done_o(e_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic exp_lsu;
        rst_ni = 1'b0; ex_valid = 1'b0; lsu_valid = 1'b0;
        ex_addr = 5'd0; lsu_addr = 5'd0; ex_data = 32'd0; lsu_data = 32'd0;
        tick(); tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
`ifdef IBEX_RF_ZERO_INIT_EN
        chk("rst_done", 32'(done), 32'd0);
        // EX request held from reset release; it must wait out the whole sweep
        rst_ni = 1'b1; ex_valid = 1'b1; ex_addr = 5'd7; ex_data = 32'hA5;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("init1_we", 32'(we), 32'd1);
            chk("init1_waddr", 32'(waddr), 32'(k));
            chk("init1_ex_ready", 32'(ex_ready), 32'd0);
        end
        rst_ni = 1'b0;
        tick();
        chk("midinit_rst_we", 32'(we), 32'd0);
        chk("midinit_rst_done", 32'(done), 32'd0);
        rst_ni = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk("init_we", 32'(we), 32'd1);
            chk("init_waddr", 32'(waddr), 32'(k));
            chk("init_wdata", wdata, 32'd0);
            chk("init_done", 32'(done), 32'(k == 31));
            chk("init_ex_ready", 32'(ex_ready), 32'(k == 31));
        end
        tick();
        ex_valid = 1'b0;
        chk("held_we", 32'(we), 32'd1);
        chk("held_waddr", 32'(waddr), 32'd7);
        chk("held_wdata", wdata, 32'hA5);
        tick();
`else
        chk("rst_done", 32'(done), 32'd1);
        rst_ni = 1'b1;
`endif

        // single EX write
        ex_valid = 1'b1; ex_addr = 5'd5; ex_data = 32'hDEADBEEF;
        #1;
        chk("single_ex_ready", 32'(ex_ready), 32'd1);
        chk("single_lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        ex_valid = 1'b0;
        chk("single_we", 32'(we), 32'd1);
        chk("single_waddr", 32'(waddr), 32'd5);
        chk("single_wdata", wdata, 32'hDEADBEEF);
        tick();
        chk("idle_we", 32'(we), 32'd0);
        chk("idle_waddr_hold", 32'(waddr), 32'd5);
        chk("idle_wdata_hold", wdata, 32'hDEADBEEF);

        // LSU write to x0 is accepted but not written
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h1234;
        #1;
        chk("x0_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("x0_ex_ready", 32'(ex_ready), 32'd0);
        tick();
        lsu_valid = 1'b0;
        chk("x0_we", 32'(we), 32'd0);
        chk("x0_waddr", 32'(waddr), 32'd0);

        // contention: LSU wins every 5th cycle (after 4 denials)
        ex_valid = 1'b1; ex_addr = 5'd1; ex_data = 32'h11;
        lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h22;
        for (int c = 0; c < 10; c++) begin
            exp_lsu = (c == 4) || (c == 9);
            #1;
            chk("cont_ex_ready", 32'(ex_ready), 32'(!exp_lsu));
            chk("cont_lsu_ready", 32'(lsu_ready), 32'(exp_lsu));
            tick();
            chk("cont_waddr", 32'(waddr), exp_lsu ? 32'd2 : 32'd1);
            chk("cont_wdata", wdata, exp_lsu ? 32'h22 : 32'h11);
        end
        ex_valid = 1'b0; lsu_valid = 1'b0;

        // RV32E masks the index to 4 bits before the x0 check
        ex_valid = 1'b1; ex_addr = 5'h13; ex_data = 32'h55;
        #1;
        chk("e_ex_ready", 32'(e_ex_ready), 32'd1);
        tick();
        chk("e13_we", 32'(e_we), 32'd1);
        chk("e13_waddr", 32'(e_waddr), 32'h03);
        chk("r13_waddr", 32'(waddr), 32'h13);
        ex_addr = 5'h10;
        tick();
        ex_valid = 1'b0;
        chk("e10_we", 32'(e_we), 32'd0);
        chk("e10_waddr", 32'(e_waddr), 32'h00);
        chk("r10_we", 32'(we), 32'd1);
        chk("r10_waddr", 32'(waddr), 32'h10);

        // reset in the same cycle as a handshake cancels the write
        ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 32'h33;
        rst_ni = 1'b0;
        tick();
        ex_valid = 1'b0;
        chk("runrst_we", 32'(we), 32'd0);
        chk("runrst_waddr", 32'(waddr), 32'd0);
`ifdef IBEX_RF_ZERO_INIT_EN
        chk("runrst_done", 32'(done), 32'd0);
`else
        chk("runrst_done", 32'(done), 32'd1);
`endif
        rst_ni = 1'b1;
        tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
